uart_program_loader: RTL
========================

# uart_program_loader

Boot-time loader sitting upstream of `program_memory`. Receives a program image over the `io_rx` UART line and writes it word by word into instruction memory. Holds the core in reset until the declared image length has been written.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868 — clock cycles per UART bit (100 MHz / 115200 baud).
- `MAX_WORDS`, default 1024 — program memory capacity in 32-bit words.
- `BASE_ADDR`, default 32'h0 — byte address of the first written word.

Ports:
- `clk` input, 1 — single clock; all logic on the rising edge.
- `reset_n` input, 1 — asynchronous, active-low reset.
- `io_rx` input, 1 — UART RX line, asynchronous to `clk`, idle high.
- `mem_write_enable` output, 1 — one-cycle write strobe to program memory.
- `mem_byte_address` output, 32 — byte address of the write; word aligned.
- `mem_write_data` output, 32 — word to write.
- `cpu_hold` output, 1 — high while loading; drives the core's `reset_n` low externally.
- `load_done` output, 1 — high once the image is complete; sticky until reset.
- `frame_error` output, 1 — sticky error flag; cleared only by reset.

## Operation
- `io_rx` passes through a 2-flop synchronizer; both flops reset to 1.
- RX FSM, states RX_IDLE, RX_START, RX_DATA, RX_STOP. 8N1 format, LSB first.
  - RX_IDLE → RX_START on a synchronized low.
  - RX_START: waits `CLKS_PER_BIT/2` cycles, then re-samples.
    - Line high: glitch; return to RX_IDLE with no error.
    - Line low: go to RX_DATA.
  - RX_DATA: samples one bit every `CLKS_PER_BIT` cycles; after 8 bits, go to RX_STOP.
  - RX_STOP: samples after `CLKS_PER_BIT` cycles.
    - High: pulse `byte_valid` for one cycle with `byte_data`.
    - Low: set `frame_error` and discard the byte; go to RX_IDLE and wait for the line to return high before accepting a new start.
- Loader FSM, states LD_LEN, LD_DATA, LD_DONE.
  - LD_LEN: collects 4 bytes little-endian into `word_count`.
    - `word_count == 0`: go to LD_DONE.
    - `word_count > MAX_WORDS`: set `frame_error`, clear the byte counter, stay in LD_LEN.
    - Otherwise: go to LD_DATA.
  - LD_DATA: byte k (k = 0..3) fills bits [8k+7:8k] of the assembly register.
    - On the 4th byte, issue a write of that word at `BASE_ADDR + 4*word_index`, then increment `word_index`.
    - After the write of word `word_count-1`, go to LD_DONE.
  - LD_DONE: `cpu_hold` = 0 and `load_done` = 1; further received bytes are ignored.
- Address arithmetic is 32-bit. `word_index` is `$clog2(MAX_WORDS+1)` bits wide and never wraps, because the length is bounded by `MAX_WORDS`.

## Timing
Reset values:
- `mem_write_enable` = 0, `mem_byte_address` = `BASE_ADDR`, `mem_write_data` = 0.
- `cpu_hold` = 1, `load_done` = 0, `frame_error` = 0.
- Both FSMs in their first state; all counters 0.

Latencies:
- `byte_valid` rises in the cycle after the stop-bit sample.
- `mem_write_enable` is high for exactly one cycle, starting the cycle after the 4th `byte_valid` of a word. Address and data are valid in that same cycle and held until the next write.
- `cpu_hold` falls and `load_done` rises in the cycle after the final write strobe, or in the cycle after the 4th length byte when the length is 0.

Boundary conditions:
- No back-pressure. Memory accepts a write every cycle, and bytes are at least 10·`CLKS_PER_BIT` cycles apart.
- A framing error inside LD_DATA discards only that byte; assembly continues with the next good byte. The host must resend the image after a reset.
- Reset mid-frame or mid-word: asynchronous clear; the partial word is never written.
- A start bit arriving in the same cycle as a write strobe has no interaction.

## Structure
- Shared package additions:
  - `rx_state_t` and `loader_state_t` enums.
  - `UART_DATA_BITS` = 8.
  - `LOADER_LEN_BYTES` = 4.
- Sub-module `uart_rx`, containing the synchronizer, the RX FSM and the bit counters. It outputs `byte_valid`, `byte_data` and `stop_error`.
- The top-level loader instantiates `uart_rx` and holds the loader FSM, the assembly register and the write-port registers.

## Test plan
The bench uses `CLKS_PER_BIT` = 16 and `BASE_ADDR` = 0.
- Send length 2 and words 0xDEADBEEF, 0x00000013. Required: writes (0x0, 0xDEADBEEF) then (0x4, 0x00000013), each strobe 1 cycle wide; `cpu_hold` falls one cycle after the second strobe.
- Send length 0. Required: no write strobe; `load_done` = 1 one cycle after the 4th length byte.
- Send a byte with stop bit 0 inside a word. Required: `frame_error` = 1, byte dropped; the next 4 good bytes form the word.
- Hold a 0.3-bit low glitch on `io_rx`. Required: no `byte_valid`, `frame_error` stays 0.
- Send length `MAX_WORDS`+1. Required: `frame_error` = 1, FSM stays in LD_LEN; a following valid length 1 plus one word loads correctly.
- Assert reset after 2 data bytes. Required: all outputs return to reset values and no write occurs.

Source files
------------

// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader and its receiver.
package uart_program_loader_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int LOADER_LEN_BYTES = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_LEN,
    LD_DATA,
    LD_DONE
  } loader_state_t;

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle byte strobe.
module uart_rx
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      io_rx,
  output logic                      byte_valid,
  output logic [UART_DATA_BITS-1:0] byte_data,
  output logic                      stop_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  logic                      rx_meta;
  logic                      rx_sync;
  rx_state_t                 state, state_next;
  logic [CNT_W-1:0]          clk_cnt, clk_cnt_next;
  logic [BIT_W-1:0]          bit_cnt, bit_cnt_next;
  logic [UART_DATA_BITS-1:0] shift_q, shift_next;
  logic                      byte_valid_next;
  logic                      stop_error_next;
  logic                      wait_high, wait_high_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= RX_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      stop_error <= 1'b0;
      wait_high  <= 1'b0;
    end else begin
      rx_meta    <= io_rx;
      rx_sync    <= rx_meta;
      state      <= state_next;
      clk_cnt    <= clk_cnt_next;
      bit_cnt    <= bit_cnt_next;
      shift_q    <= shift_next;
      byte_valid <= byte_valid_next;
      stop_error <= stop_error_next;
      wait_high  <= wait_high_next;
    end
  end

  // After a bad stop bit the line may still be low; wait_high blocks a false start.
  always_comb begin
    state_next      = state;
    clk_cnt_next    = clk_cnt;
    bit_cnt_next    = bit_cnt;
    shift_next      = shift_q;
    byte_valid_next = 1'b0;
    stop_error_next = 1'b0;
    wait_high_next  = wait_high;
    case (state)
      RX_IDLE: begin
        if (rx_sync) begin
          wait_high_next = 1'b0;
        end else if (!wait_high) begin
          state_next   = RX_START;
          clk_cnt_next = '0;
        end
      end
      RX_START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {rx_sync, shift_q[UART_DATA_BITS-1:1]};
          if (bit_cnt == BIT_LAST) begin
            state_next = RX_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_next = '0;
          state_next   = RX_IDLE;
          if (rx_sync) begin
            byte_valid_next = 1'b1;
          end else begin
            stop_error_next = 1'b1;
            wait_high_next  = 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed program image over UART and writes it
// word by word into program memory, holding the core in reset until complete.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          MAX_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_rx,
  output logic        mem_write_enable,
  output logic [31:0] mem_byte_address,
  output logic [31:0] mem_write_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        frame_error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);
  localparam int BC_W  = $clog2(LOADER_LEN_BYTES);
  localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(LOADER_LEN_BYTES - 1);

  logic                      byte_valid;
  logic [UART_DATA_BITS-1:0] byte_data;
  logic                      stop_error;

  loader_state_t    ld_state, ld_state_next;
  logic [BC_W-1:0]  byte_cnt, byte_cnt_next;
  logic [31:0]      word_count, word_count_next;
  logic [IDX_W-1:0] word_index, word_index_next;
  logic [31:0]      assembly, assembly_next;
  logic             we_next;
  logic [31:0]      addr_next;
  logic [31:0]      data_next;
  logic             frame_error_next;
  logic [31:0]      len_full;
  logic [31:0]      word_full;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .io_rx     (io_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .stop_error(stop_error)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_state         <= LD_LEN;
      byte_cnt         <= '0;
      word_count       <= '0;
      word_index       <= '0;
      assembly         <= '0;
      mem_write_enable <= 1'b0;
      mem_byte_address <= BASE_ADDR;
      mem_write_data   <= '0;
      frame_error      <= 1'b0;
    end else begin
      ld_state         <= ld_state_next;
      byte_cnt         <= byte_cnt_next;
      word_count       <= word_count_next;
      word_index       <= word_index_next;
      assembly         <= assembly_next;
      mem_write_enable <= we_next;
      mem_byte_address <= addr_next;
      mem_write_data   <= data_next;
      frame_error      <= frame_error_next;
    end
  end

  // Little-endian placement of the incoming byte into the length or data word.
  always_comb begin
    len_full  = word_count;
    word_full = assembly;
    len_full[{byte_cnt, 3'b000} +: 8]  = byte_data;
    word_full[{byte_cnt, 3'b000} +: 8] = byte_data;
  end

  always_comb begin
    ld_state_next    = ld_state;
    byte_cnt_next    = byte_cnt;
    word_count_next  = word_count;
    word_index_next  = word_index;
    assembly_next    = assembly;
    we_next          = 1'b0;
    addr_next        = mem_byte_address;
    data_next        = mem_write_data;
    frame_error_next = frame_error | stop_error;
    case (ld_state)
      LD_LEN: begin
        if (byte_valid) begin
          word_count_next = len_full;
          if (byte_cnt == BYTE_LAST) begin
            byte_cnt_next = '0;
            if (len_full == 32'd0) begin
              ld_state_next = LD_DONE;
            end else if (len_full > 32'(MAX_WORDS)) begin
              frame_error_next = 1'b1;
            end else begin
              ld_state_next   = LD_DATA;
              word_index_next = '0;
            end
          end else begin
            byte_cnt_next = byte_cnt + 1'b1;
          end
        end
      end
      LD_DATA: begin
        // Leave one cycle after the final strobe so the core is released after it.
        if (mem_write_enable && (32'(word_index) == word_count)) begin
          ld_state_next = LD_DONE;
        end else if (byte_valid) begin
          assembly_next = word_full;
          if (byte_cnt == BYTE_LAST) begin
            byte_cnt_next   = '0;
            we_next         = 1'b1;
            addr_next       = BASE_ADDR + 32'({word_index, 2'b00});
            data_next       = word_full;
            word_index_next = word_index + 1'b1;
          end else begin
            byte_cnt_next = byte_cnt + 1'b1;
          end
        end
      end
      LD_DONE: ;
      default: ld_state_next = LD_LEN;
    endcase
  end

  assign cpu_hold  = (ld_state != LD_DONE);
  assign load_done = (ld_state == LD_DONE);

endmodule
